// File: rtl/pmc_th_scan_if.sv
// Threshold-scan sequencer bus.
// master: scan control, scan configuration and CPU threshold in; matrix threshold and status out.
// slave : the sequencer side of the same signals.
interface pmc_th_scan_if #(
    parameter int unsigned TH_W  = 8,
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [TH_W-1:0]  th_start;
    logic [TH_W-1:0]  th_stop;
    logic [TH_W-1:0]  th_step;
    logic [CNT_W-1:0] dwell;
    logic [TH_W-1:0]  cpu_th;
    logic [TH_W-1:0]  th_out;
    logic             busy;
    logic             step_strobe;
    logic             done;
    logic             err;

    modport master (
        output start, abort, th_start, th_stop, th_step, dwell, cpu_th,
        input  th_out, busy, step_strobe, done, err
    );

    modport slave (
        input  start, abort, th_start, th_stop, th_step, dwell, cpu_th,
        output th_out, busy, step_strobe, done, err
    );
endinterface

// File: rtl/pmc_th_scan.sv
// Threshold-scan sequencer: passes the CPU threshold through when idle; on start,
// steps the matrix threshold from th_start towards th_stop by th_step, holding each
// value for dwell cycles (0 behaves as 1) and strobing the last cycle of each value.
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   io_bus - pmc_th_scan_if.slave (start/abort, scan config, cpu_th in;
//            th_out, busy, step_strobe, done, err out)
module pmc_th_scan #(
    parameter int unsigned TH_W  = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    pmc_th_scan_if.slave      io_bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [TH_W-1:0]   r_cur;
    logic [TH_W-1:0]   r_stop;
    logic [TH_W-1:0]   r_step;
    logic [CNT_W-1:0]  r_dwell;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;

    logic              w_cfg_ok;
    logic              w_req;
    logic              w_accept;
    logic              w_reject;
    logic [CNT_W-1:0]  w_last_cnt;
    logic              w_last;
    logic [TH_W:0]     w_nxt;
    logic              w_over;

    // Start qualification; a simultaneous abort cancels the request silently.
    assign w_cfg_ok = (io_bus.th_step != '0) && (io_bus.th_start <= io_bus.th_stop);
    assign w_req    = (r_state == S_IDLE) && io_bus.start && !io_bus.abort;
    assign w_accept = w_req && w_cfg_ok;
    assign w_reject = w_req && !w_cfg_ok;

    // Final count of a dwell; a latched dwell of 0 behaves like 1.
    assign w_last_cnt = (r_dwell == '0) ? '0 : (r_dwell - CNT_W'(1));
    assign w_last     = (r_cnt == w_last_cnt);

    // One extra bit so a carry out of TH_W also ends the scan instead of wrapping.
    assign w_nxt  = {1'b0, r_cur} + {1'b0, r_step};
    assign w_over = (w_nxt > {1'b0, r_stop});

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_DWELL;
                end
            end
            S_DWELL: begin
                if (io_bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_last && w_over) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decode from state and datapath registers only.
    always_comb begin
        io_bus.th_out      = io_bus.cpu_th;
        io_bus.busy        = 1'b0;
        io_bus.step_strobe = 1'b0;
        io_bus.done        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
            end
            S_DWELL: begin
                io_bus.th_out      = r_cur;
                io_bus.busy        = 1'b1;
                io_bus.step_strobe = w_last;
            end
            S_DONE: begin
                io_bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign io_bus.err = r_err;

    // Shadow config, current threshold and dwell counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur   <= '0;
            r_stop  <= '0;
            r_step  <= '0;
            r_dwell <= '0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cur   <= io_bus.th_start;
                        r_stop  <= io_bus.th_stop;
                        r_step  <= io_bus.th_step;
                        r_dwell <= io_bus.dwell;
                        r_cnt   <= '0;
                    end
                end
                S_DWELL: begin
                    if (io_bus.abort) begin
                        r_cnt <= '0;
                    end else if (w_last) begin
                        r_cnt <= '0;
                        if (!w_over) begin
                            r_cur <= w_nxt[TH_W-1:0];
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // Rejected-start pulse, visible the cycle after the request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_reject;
        end
    end

endmodule
